// File: rtl/amo_lrsc_unit.sv
// Atomic memory op / LR-SC unit: computes AMO, load and store results one cycle after
// acceptance and tracks a single load-reserved granule with a timed lifetime.
module amo_lrsc_unit #(
  parameter int DATA_W      = 64,
  parameter int ADDR_W      = 40,
  parameter int BLOCK_OFF   = 6,
  parameter int LRSC_CYCLES = 80
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [4:0]          req_cmd,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [1:0]          req_size,
  input  logic [DATA_W-1:0]   req_old,
  input  logic [DATA_W-1:0]   req_operand,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic [DATA_W-1:0]   resp_wdata,
  output logic [DATA_W/8-1:0] resp_wmask,
  input  logic                probe_valid,
  input  logic [ADDR_W-1:0]   probe_addr,
  output logic                resv_valid
);
  // state    | meaning
  // S_IDLE   | no reservation held
  // S_RESERVED | reservation on resv_blk_q, lifetime counting down in cnt_q

  localparam int MASK_W = DATA_W / 8;
  localparam int BLK_W  = ADDR_W - BLOCK_OFF;

  localparam logic [4:0] M_XRD     = 5'h00;
  localparam logic [4:0] M_XWR     = 5'h01;
  localparam logic [4:0] M_XA_SWAP = 5'h04;
  localparam logic [4:0] M_XLR     = 5'h06;
  localparam logic [4:0] M_XSC     = 5'h07;
  localparam logic [4:0] M_XA_ADD  = 5'h08;
  localparam logic [4:0] M_XA_XOR  = 5'h09;
  localparam logic [4:0] M_XA_OR   = 5'h0A;
  localparam logic [4:0] M_XA_AND  = 5'h0B;
  localparam logic [4:0] M_XA_MIN  = 5'h0C;
  localparam logic [4:0] M_XA_MAX  = 5'h0D;
  localparam logic [4:0] M_XA_MINU = 5'h0E;
  localparam logic [4:0] M_XA_MAXU = 5'h0F;
  localparam logic [4:0] M_PWR     = 5'h11;

  typedef enum logic {S_IDLE, S_RESERVED} state_e;

  state_e              state_q, state_d;
  logic [9:0]          cnt_q, cnt_d;
  logic [BLK_W-1:0]    resv_blk_q, resv_blk_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;

  logic                accept, dword, lane, probe_hit, sc_ok, lt_s, lt_u;
  logic [5:0]          lane_sh;
  logic [31:0]         old_w, op_w;
  logic [DATA_W-1:0]   old_s, old_u, op_s, op_u, amo_res, store_pos;
  logic [MASK_W-1:0]   full_mask;
  logic [BLK_W-1:0]    req_blk, probe_blk;
  logic                unused_addr_bits;

  assign req_ready  = !resp_valid_q || resp_ready;
  assign accept     = req_valid && req_ready;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_wdata = wdata_q;
  assign resp_wmask = wmask_q;
  assign resv_valid = (state_q == S_RESERVED);

  assign dword   = (DATA_W == 64) && (req_size == 2'd3);
  assign lane    = (DATA_W == 64) && req_addr[2];
  assign lane_sh = {lane, 5'b0};
  assign old_w   = req_old[lane_sh +: 32];
  assign op_w    = req_operand[31:0];

  // Word operands are extended to full width so one comparator serves both sizes.
  assign old_s = dword ? req_old     : DATA_W'($signed(old_w));
  assign old_u = dword ? req_old     : DATA_W'(old_w);
  assign op_s  = dword ? req_operand : DATA_W'($signed(op_w));
  assign op_u  = dword ? req_operand : DATA_W'(op_w);
  assign lt_s  = $signed(old_s) < $signed(op_s);
  assign lt_u  = old_u < op_u;

  assign full_mask = dword ? {MASK_W{1'b1}} : (MASK_W'(4'hF) << {lane, 2'b0});

  assign req_blk   = req_addr[ADDR_W-1:BLOCK_OFF];
  assign probe_blk = probe_addr[ADDR_W-1:BLOCK_OFF];
  assign probe_hit = probe_valid && (probe_blk == resv_blk_q);
  // A probe landing in the same cycle as the SC already kills it.
  assign sc_ok     = (state_q == S_RESERVED) && (req_blk == resv_blk_q) && !probe_hit;

  assign unused_addr_bits = ^{req_addr[BLOCK_OFF-1:0], probe_addr[BLOCK_OFF-1:0]};

  always_comb begin
    amo_res = op_s;
    case (req_cmd)
      M_XA_ADD:  amo_res = old_s + op_s;
      M_XA_XOR:  amo_res = old_s ^ op_s;
      M_XA_OR:   amo_res = old_s | op_s;
      M_XA_AND:  amo_res = old_s & op_s;
      M_XA_MIN:  amo_res = lt_s ? old_s : op_s;
      M_XA_MAX:  amo_res = lt_s ? op_s : old_s;
      M_XA_MINU: amo_res = lt_u ? old_s : op_s;
      M_XA_MAXU: amo_res = lt_u ? op_s : old_s;
      default:   amo_res = op_s;
    endcase
    store_pos = dword ? amo_res : (DATA_W'(amo_res[31:0]) << lane_sh);
  end

  always_comb begin
    rdata_d = '0;
    wdata_d = '0;
    wmask_d = '0;
    case (req_cmd)
      M_XRD, M_XLR: rdata_d = old_s;
      M_XWR, M_PWR: begin
        wdata_d = store_pos;
        wmask_d = full_mask;
      end
      M_XSC: begin
        if (sc_ok) begin
          wdata_d = store_pos;
          wmask_d = full_mask;
        end else begin
          rdata_d = DATA_W'(1);
        end
      end
      M_XA_SWAP, M_XA_ADD, M_XA_XOR, M_XA_OR, M_XA_AND,
      M_XA_MIN, M_XA_MAX, M_XA_MINU, M_XA_MAXU: begin
        rdata_d = old_s;
        wdata_d = store_pos;
        wmask_d = full_mask;
      end
      default: ;
    endcase
    resp_valid_d = accept || (resp_valid_q && !resp_ready);
  end

  // Later assignments take priority: LR beats probe, expiry and SC in the same cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    resv_blk_d = resv_blk_q;
    if (state_q == S_RESERVED) begin
      if (cnt_q == 10'd0) state_d = S_IDLE;
      else                cnt_d   = cnt_q - 10'd1;
    end
    if (probe_hit) state_d = S_IDLE;
    if (accept && req_cmd == M_XSC) state_d = S_IDLE;
    if (accept && req_cmd == M_XLR) begin
      state_d    = S_RESERVED;
      cnt_d      = 10'(LRSC_CYCLES - 1);
      resv_blk_d = req_blk;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      resv_blk_q   <= '0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resv_blk_q   <= resv_blk_d;
      resp_valid_q <= resp_valid_d;
      if (accept) begin
        rdata_q <= rdata_d;
        wdata_q <= wdata_d;
        wmask_q <= wmask_d;
      end
    end
  end

endmodule

// File: doc/amo_lrsc_unit.md
AMO_LRSC_UNIT -- requirements
Module: amo_lrsc_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 64, data path width; legal values 32 and 64.
REQ-002 SHALL have parameter ADDR_W, default 40, byte-address width.
REQ-003 SHALL have parameter BLOCK_OFF, default 6, log2 of the reservation-granule size in bytes.
REQ-004 SHALL have parameter LRSC_CYCLES, default 80, reservation lifetime in cycles (1..1023).
REQ-005 SHALL have port clock  in  1  the only clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  in  1  reset, asynchronous and active-high.
REQ-007 SHALL have port req_valid  in  1  request offered.
REQ-008 SHALL have port req_ready  out  1  request accepted when high together with req_valid.
REQ-009 SHALL have port req_cmd  in  5  memory op code (M_XRD, M_XWR, M_XLR, M_XSC, M_PWR, M_XA_*).
REQ-010 SHALL have port req_addr  in  ADDR_W  byte address.
REQ-011 SHALL have port req_size  in  2  2 = word, 3 = doubleword (3 legal only if DATA_W=64).
REQ-012 SHALL have port req_old  in  DATA_W  current memory data for the aligned DATA_W beat.
REQ-013 SHALL have port req_operand  in  DATA_W  store/AMO operand, right-aligned.
REQ-014 SHALL have port resp_valid  out  1  result held.
REQ-015 SHALL have port resp_ready  in  1  consumer takes result.
REQ-016 SHALL have port resp_rdata  out  DATA_W  value returned to core, sign-extended.
REQ-017 SHALL have port resp_wdata  out  DATA_W  data to write to memory, lane-positioned.
REQ-018 SHALL have port resp_wmask  out  DATA_W/8  byte enables for resp_wdata; all zero when no write.
REQ-019 SHALL have port probe_valid  in  1  external invalidation of the block at probe_addr.
REQ-020 SHALL have port probe_addr  in  ADDR_W  probed address.
REQ-021 SHALL have port resv_valid  out  1  reservation currently held.

Function
REQ-022 SHALL have a single output register stage: req_ready = !resp_valid || resp_ready, and a request is accepted on req_valid && req_ready.
REQ-023 SHALL present every result on resp_* exactly one cycle after acceptance and hold it stable until resp_valid && resp_ready.
REQ-024 SHALL, for word ops with DATA_W=64, select the lane by req_addr[2] and place wdata/wmask in that lane; doubleword ops use the full beat.
REQ-025 SHALL set rdata = sign-extended selected lane of req_old for M_XRD, M_XLR and all M_XA_*, with an all-zero wmask for M_XRD and M_XLR.
REQ-026 SHALL, for M_XWR and M_PWR, write the operand with the lane's full mask and return rdata = 0.
REQ-027 SHALL compute M_XA_* as SWAP=op, ADD=old+op (wrap-around modulo size), XOR, OR, AND, MIN/MAX signed and MINU/MAXU unsigned at operand size, writing with the lane's full mask.
REQ-028 SHALL treat any other cmd as a no-op: rdata = 0, wmask = 0, no reservation change.
REQ-029 SHALL keep a two-state reservation FSM: IDLE, RESERVED, together with resv_blk = addr[ADDR_W-1:BLOCK_OFF] and a countdown counter.
REQ-030 SHALL, on an accepted M_XLR, enter RESERVED, load resv_blk and set the counter to LRSC_CYCLES-1; a new LR while RESERVED re-arms both.
REQ-031 SHALL, in RESERVED, decrement the counter each cycle and go to IDLE on the cycle after it reads 0.
REQ-032 SHALL, on an accepted M_XSC, succeed iff the state is RESERVED and blocks match before this cycle's update: on success rdata=0 and write operand; on failure rdata=1 and wmask=0.
REQ-033 SHALL return to IDLE after any accepted M_XSC.
REQ-034 SHALL, on probe_valid with a probe block equal to resv_blk, go to IDLE.
REQ-035 SHALL resolve simultaneous events this way: SC and a matching probe in the same cycle give SC failure; LR and a probe in the same cycle let LR win; an M_XWR or AMO to the reserved block leaves the reservation intact.
REQ-036 SHALL drive resv_valid = (state == RESERVED).

Reset
REQ-037 SHALL, on reset assertion at any time including mid-transaction, immediately clear resp_valid, resp_rdata, resp_wdata, resp_wmask, the counter and resv_blk, enter IDLE, and drop any in-flight result.
REQ-038 SHALL hold req_ready = 1 during and after reset.

Verification
REQ-039 Scenario: DATA_W=64, M_XA_ADD size 3, old=0xFFFFFFFFFFFFFFFF, op=1 -> rdata=0xFFFFFFFFFFFFFFFF, wdata=0, wmask=0xFF, one cycle later.
REQ-040 Scenario: M_XA_MIN size 2, addr[2]=1, old[63:32]=0x80000000, op=0x00000001 -> rdata=0xFFFFFFFF80000000, wdata[63:32]=0x80000000, wmask=0xF0.
REQ-041 Scenario: M_XLR at 0x1000, then M_XSC at 0x1038 10 cycles later -> SC rdata=0, wmask=0xFF, resv_valid=0 afterwards.
REQ-042 Scenario: M_XLR at 0x1000, probe 0x1020 in the same cycle as the M_XSC -> SC rdata=1, wmask=0.
REQ-043 Scenario: LRSC_CYCLES=4, M_XLR then M_XSC issued 5 cycles later -> resv_valid drops after 4 cycles and SC fails (rdata=1).
REQ-044 Scenario: resp_ready held low 3 cycles with a second request pending, then reset pulsed -> resp held stable and req_ready=0 while stalled; after reset resp_valid=0, resv_valid=0, req_ready=1.
